random_math_vm: RTL and testbench

- Parametrised random-math VM for the CNv4 hash core; successor to the fixed 9-register, 32-bit engine.
- Loads a register file from the hash datapath on start, then fetches and executes instructions from an external synchronous program RAM until RET, an error, or the instruction budget runs out.
- Adds true rotates, operand range checking, an instruction watchdog, busy/done/error status and an executed-instruction count.

---
 rtl/random_math_vm.sv | 182 ++++++++++++++++++
 tb/tb_random_math_vm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/random_math_vm.sv
// random_math_vm: parametrised random-math VM for the CNv4 hash core.
// Loads a register file on start, then runs {opcode,dst,src,imm} words from a synchronous program RAM.
module random_math_vm #(
   parameter int DW        = 32,
   parameter int NUM_REGS  = 9,
   parameter int AW        = 8,
   parameter int MAX_INSTR = 256
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [NUM_REGS*DW-1:0] in_regs,
   output logic [AW-1:0]          prog_addr,
   input  logic [24+DW-1:0]       prog_rdata,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [AW:0]            instr_count,
   output logic [NUM_REGS*DW-1:0] out_regs
);
   localparam int          SW       = $clog2(DW);
   localparam logic [8:0]  NREG_L   = NUM_REGS[8:0];
   localparam logic [AW:0] MAX_L    = MAX_INSTR[AW:0];
   localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   localparam logic [7:0] OP_MUL = 8'd0;
   localparam logic [7:0] OP_ADD = 8'd1;
   localparam logic [7:0] OP_SUB = 8'd2;
   localparam logic [7:0] OP_ROR = 8'd3;
   localparam logic [7:0] OP_ROL = 8'd4;
   localparam logic [7:0] OP_XOR = 8'd5;
   localparam logic [7:0] OP_RET = 8'd6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state_r, state_nx_s;
   logic [DW-1:0]   regs_r [NUM_REGS];
   logic [AW-1:0]   prog_addr_r;
   logic [AW:0]     cnt_r;
   logic            busy_r, done_r, error_r;
   logic [7:0]      opcode_s, dst_s, src_s;
   logic [DW-1:0]   imm_s, a_s, b_s, res_s;
   logic            legal_s, wr_en_s, err_s;

   // Rotation by concatenating the operand with itself; shift amount is already reduced mod DW.
   function automatic logic [DW-1:0] ror_f(input logic [DW-1:0] a, input logic [SW-1:0] sh);
      logic [2*DW-1:0] t;
      t = {a, a} >> sh;
      return t[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] rol_f(input logic [DW-1:0] a, input logic [SW-1:0] sh);
      logic [2*DW-1:0] t;
      t = {a, a} << sh;
      return t[2*DW-1:DW];
   endfunction

   assign opcode_s = prog_rdata[DW+23:DW+16];
   assign dst_s    = prog_rdata[DW+15:DW+8];
   assign src_s    = prog_rdata[DW+7:DW];
   assign imm_s    = prog_rdata[DW-1:0];

   // Operand fetch and range check; both operands read the pre-instruction register values.
   always_comb begin
      a_s = {DW{1'b0}};
      b_s = {DW{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         a_s = (dst_s == 8'(i)) ? regs_r[i] : a_s;
         b_s = (src_s == 8'(i)) ? regs_r[i] : b_s;
      end
      legal_s = (opcode_s <= OP_XOR) && ({1'b0, dst_s} < NREG_L) && ({1'b0, src_s} < NREG_L);
   end

   // ALU result for the instruction currently on prog_rdata.
   always_comb begin
      res_s = {DW{1'b0}};
      case (opcode_s)
         OP_MUL:  res_s = a_s * b_s;
         OP_ADD:  res_s = a_s + b_s + imm_s;
         OP_SUB:  res_s = a_s - b_s;
         OP_ROR:  res_s = ror_f(a_s, b_s[SW-1:0]);
         OP_ROL:  res_s = rol_f(a_s, b_s[SW-1:0]);
         OP_XOR:  res_s = a_s ^ b_s;
         default: res_s = {DW{1'b0}};
      endcase
   end

   // Next-state decode; the watchdog fires before a non-RET instruction would exceed the budget.
   always_comb begin
      state_nx_s = state_r;
      wr_en_s    = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nx_s = ST_FETCH;
            else       state_nx_s = ST_IDLE;
         end
         ST_FETCH: state_nx_s = ST_EXEC;
         ST_EXEC: begin
            if (opcode_s == OP_RET) begin
               state_nx_s = ST_DONE;
            end else if (!legal_s || (cnt_r == MAX_L)) begin
               state_nx_s = ST_DONE;
               err_s      = 1'b1;
            end else begin
               wr_en_s    = 1'b1;
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register and registered busy flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s == ST_FETCH) || (state_nx_s == ST_EXEC);
      end
   end

   // Register file, program counter, instruction count and status flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DW{1'b0}};
         prog_addr_r <= {AW{1'b0}};
         cnt_r       <= {(AW+1){1'b0}};
         done_r      <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= in_regs[i*DW +: DW];
                  prog_addr_r <= {AW{1'b0}};
                  cnt_r       <= {(AW+1){1'b0}};
                  error_r     <= 1'b0;
               end
            end
            ST_FETCH: prog_addr_r <= prog_addr_r + ADDR_ONE;
            ST_EXEC: begin
               // Saturate rather than wrap; the watchdog ends the run before this matters.
               if (prog_addr_r != {AW{1'b1}}) prog_addr_r <= prog_addr_r + ADDR_ONE;
               if (wr_en_s) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (dst_s == 8'(i)) regs_r[i] <= res_s;
                  end
                  cnt_r <= cnt_r + CNT_ONE;
               end
               if (state_nx_s == ST_DONE) begin
                  done_r  <= 1'b1;
                  error_r <= err_s;
               end
            end
            default: done_r <= 1'b0;
         endcase
      end
   end

   // Live register file view.
   always_comb begin
      out_regs = {(NUM_REGS*DW){1'b0}};
      for (int i = 0; i < NUM_REGS; i++) out_regs[i*DW +: DW] = regs_r[i];
   end

   assign prog_addr   = prog_addr_r;
   assign instr_count = cnt_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign error       = error_r;

endmodule

// File: tb/tb_random_math_vm.sv
// Directed self-checking bench for random_math_vm with a synchronous program RAM model.
// MAX_INSTR is set to 4 so the watchdog is reachable with a short program.
module tb_random_math_vm;
   localparam int DW = 32, NR = 9, AW = 8, MI = 4;
   localparam int RW = NR*DW;

   logic            clk = 1'b0;
   logic            reset_n, start;
   logic [RW-1:0]   in_regs, out_regs, exp_v;
   logic [AW-1:0]   prog_addr;
   logic [24+DW-1:0] prog_rdata;
   logic            busy, done, error;
   logic [AW:0]     instr_count;
   logic [24+DW-1:0] mem [256];
   int              n_cmp = 0, n_bad = 0;
   int              lat;

   random_math_vm #(.DW(DW), .NUM_REGS(NR), .AW(AW), .MAX_INSTR(MI)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .in_regs(in_regs),
      .prog_addr(prog_addr), .prog_rdata(prog_rdata), .busy(busy), .done(done),
      .error(error), .instr_count(instr_count), .out_regs(out_regs)
   );

   always #5 clk = ~clk;

   always @(posedge clk) prog_rdata <= mem[prog_addr];

   task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [24+DW-1:0] enc(input logic [7:0] op, input logic [7:0] d,
                                            input logic [7:0] s, input logic [DW-1:0] imm);
      return {op, d, s, imm};
   endfunction

   function automatic logic [DW-1:0] rd(input int idx);
      return out_regs[idx*DW +: DW];
   endfunction

   // Pulse start, then count edges after the start edge until done; poke raises start once mid-run.
   task automatic run_prog(input int poke, output int lat_o);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check_val("busy_after_start", busy, 1);
      lat_o = -1;
      for (int c = 1; c <= 40 && lat_o < 0; c++) begin
         start = (c - 1 == poke) ? 1'b1 : 1'b0;
         @(negedge clk);
         if (done) lat_o = c;
      end
      start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; in_regs = '0;
      for (int i = 0; i < 256; i++) mem[i] = enc(8'd6, 8'd0, 8'd0, 32'd0);
      repeat (3) @(negedge clk);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_error", error, 0);
      check_val("rst_count", instr_count, 0);
      check_val("rst_addr", prog_addr, 0);
      check_val("rst_regs", out_regs, 0);
      reset_n = 1'b1;

      // ADD + RET: 10 + 3 + 5 = 18; RET executes at k+3 so done appears on that edge.
      in_regs = '0; in_regs[0*DW +: DW] = 32'd10; in_regs[1*DW +: DW] = 32'd3;
      mem[0] = enc(8'd1, 8'd0, 8'd1, 32'd5); mem[1] = enc(8'd6, 8'd0, 8'd0, 32'd0);
      run_prog(-1, lat);
      check_val("add_lat", lat, 3);
      check_val("add_r0", rd(0), 32'd18);
      check_val("add_r1", rd(1), 32'd3);
      check_val("add_count", instr_count, 1);
      check_val("add_error", error, 0);
      check_val("add_busy_done", busy, 0);
      // start during the DONE cycle must not launch a run
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      check_val("done_pulse_1cyc", done, 0);
      check_val("start_in_done_ignored", busy, 0);

      // ROR by 33 == ROR by 1
      in_regs = '0; in_regs[2*DW +: DW] = 32'h8000_0001; in_regs[3*DW +: DW] = 32'd33;
      mem[0] = enc(8'd3, 8'd2, 8'd3, 32'd0);
      run_prog(-1, lat);
      check_val("ror_r2", rd(2), 32'hC000_0000);
      in_regs[3*DW +: DW] = 32'd4;
      mem[0] = enc(8'd4, 8'd2, 8'd3, 32'd0);
      run_prog(-1, lat);
      check_val("rol_r2", rd(2), 32'h0000_0018);

      // MUL square and SUB wrap
      in_regs = '0; in_regs[4*DW +: DW] = 32'hFFFF_FFFF; in_regs[6*DW +: DW] = 32'd1;
      mem[0] = enc(8'd0, 8'd4, 8'd4, 32'd0);
      mem[1] = enc(8'd2, 8'd5, 8'd6, 32'd0);
      mem[2] = enc(8'd6, 8'd0, 8'd0, 32'd0);
      run_prog(-1, lat);
      check_val("mul_r4", rd(4), 32'h0000_0001);
      check_val("sub_r5", rd(5), 32'hFFFF_FFFF);
      check_val("mulsub_count", instr_count, 2);

      // dst out of range after one good XOR: r7 = 0x1234 ^ 0x00FF
      in_regs = '0;
      for (int i = 0; i < NR; i++) in_regs[i*DW +: DW] = 32'h100 + i;
      in_regs[7*DW +: DW] = 32'h1234; in_regs[8*DW +: DW] = 32'h00FF;
      mem[0] = enc(8'd5, 8'd7, 8'd8, 32'd0);
      mem[1] = enc(8'd1, 8'd9, 8'd0, 32'd0);
      mem[2] = enc(8'd6, 8'd0, 8'd0, 32'd0);
      run_prog(-1, lat);
      exp_v = in_regs; exp_v[7*DW +: DW] = 32'h12CB;
      check_val("dst_err_lat", lat, 3);
      check_val("dst_err_error", error, 1);
      check_val("dst_err_count", instr_count, 1);
      check_val("dst_err_regs", out_regs, exp_v);

      // opcode 7 as the first instruction
      mem[0] = enc(8'd7, 8'd0, 8'd1, 32'd0);
      run_prog(-1, lat);
      check_val("op7_lat", lat, 2);
      check_val("op7_error", error, 1);
      check_val("op7_count", instr_count, 0);
      check_val("op7_regs", out_regs, in_regs);

      // src out of range
      mem[0] = enc(8'd1, 8'd0, 8'd200, 32'd0);
      run_prog(-1, lat);
      check_val("src_err_error", error, 1);
      check_val("src_err_regs", out_regs, in_regs);

      // Watchdog: eight XORs into r0 from one-hot regs, only four execute -> 1^2^4^8
      in_regs = '0;
      for (int i = 1; i < NR; i++) in_regs[i*DW +: DW] = 32'd1 << (i - 1);
      for (int i = 0; i < 8; i++) mem[i] = enc(8'd5, 8'd0, 8'(i + 1), 32'd0);
      mem[8] = enc(8'd6, 8'd0, 8'd0, 32'd0);
      run_prog(-1, lat);
      check_val("wd_lat", lat, 6);
      check_val("wd_count", instr_count, 4);
      check_val("wd_error", error, 1);
      check_val("wd_r0", rd(0), 32'd15);
      repeat (3) @(negedge clk);
      check_val("wd_error_held", error, 1);

      // New run clears error
      mem[0] = enc(8'd1, 8'd0, 8'd1, 32'd0); mem[1] = enc(8'd6, 8'd0, 8'd0, 32'd0);
      run_prog(-1, lat);
      check_val("clear_error", error, 0);
      check_val("clear_r0", rd(0), 32'd1);

      // start during EXEC is ignored: three XORs then RET
      in_regs = '0;
      in_regs[1*DW +: DW] = 32'd1; in_regs[2*DW +: DW] = 32'd2; in_regs[3*DW +: DW] = 32'd4;
      for (int i = 0; i < 3; i++) mem[i] = enc(8'd5, 8'd0, 8'(i + 1), 32'd0);
      mem[3] = enc(8'd6, 8'd0, 8'd0, 32'd0);
      run_prog(2, lat);
      check_val("ign_lat", lat, 5);
      check_val("ign_count", instr_count, 3);
      check_val("ign_r0", rd(0), 32'd7);

      // Reset while in EXEC
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("mid_busy", busy, 1);
      reset_n = 1'b0;
      @(negedge clk);
      check_val("midrst_regs", out_regs, 0);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_addr", prog_addr, 0);
      check_val("midrst_count", instr_count, 0);
      reset_n = 1'b1;
      run_prog(-1, lat);
      check_val("post_rst_lat", lat, 5);
      check_val("post_rst_r0", rd(0), 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
